// File: rtl/axi_mem_responder.sv
// AXI3-style memory responder: independent write and read FSMs over a
// simple dual-port 64-bit word array, fixed 8-byte beats, FIXED/INCR bursts.
module axi_mem_responder #(
  parameter int unsigned AxiIdW = 6,
  parameter int unsigned MemAW  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AxiIdW-1:0] axi_awid,
  input  logic [31:0]       axi_awaddr,
  input  logic [3:0]        axi_awlen,
  input  logic [1:0]        axi_awburst,
  input  logic              axi_awvalid,
  output logic              axi_awreadyo,
  input  logic [63:0]       axi_wdata,
  input  logic [7:0]        axi_wstrb,
  input  logic              axi_wlast,
  input  logic              axi_wvalid,
  output logic              axi_wreadyo,
  output logic [AxiIdW-1:0] axi_bido,
  output logic [1:0]        axi_brespo,
  output logic              axi_bvalido,
  input  logic              axi_bready,
  input  logic [AxiIdW-1:0] axi_arid,
  input  logic [31:0]       axi_araddr,
  input  logic [3:0]        axi_arlen,
  input  logic [1:0]        axi_arburst,
  input  logic              axi_arvalid,
  output logic              axi_arreadyo,
  output logic [AxiIdW-1:0] axi_rido,
  output logic [63:0]       axi_rdatao,
  output logic [1:0]        axi_rrespo,
  output logic              axi_rlasto,
  output logic              axi_rvalido,
  input  logic              axi_rready
);

  localparam int unsigned DataW = 64;
  localparam int unsigned StrbW = 8;
  localparam int unsigned Depth = 2 ** MemAW;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]        w_state_q, w_state_d;
  logic [AxiIdW-1:0] w_id_q, w_id_d;
  logic [MemAW-1:0]  w_addr_q, w_addr_d;
  logic [3:0]        w_len_q, w_len_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic [3:0]        w_cnt_q, w_cnt_d;
  logic              w_err_q, w_err_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [AxiIdW-1:0] bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [1:0]        r_state_q, r_state_d;
  logic [AxiIdW-1:0] r_id_q, r_id_d;
  logic [MemAW-1:0]  r_addr_q, r_addr_d;
  logic [3:0]        r_len_q, r_len_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic [3:0]        r_cnt_q, r_cnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [AxiIdW-1:0] rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DataW-1:0]  rdata_q;

  logic [DataW-1:0]  mem_q [Depth];
  logic              w_hs_c;
  logic              mem_we_c;
  logic              r_load_c;
  logic              unused_addr_c;

  // Upper address bits alias onto the array; byte offset is ignored.
  assign unused_addr_c = ^{axi_awaddr[31:MemAW+3], axi_awaddr[2:0],
                           axi_araddr[31:MemAW+3], axi_araddr[2:0]};

  assign w_hs_c   = wready_q & axi_wvalid;
  assign mem_we_c = w_hs_c & reset & ~w_burst_q[1];

  // Write channel next-state
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (axi_awvalid && awready_q) begin
          w_id_d    = axi_awid;
          w_addr_d  = axi_awaddr[MemAW+2:3];
          w_len_d   = axi_awlen;
          w_burst_d = axi_awburst;
          w_cnt_d   = 4'd0;
          w_err_d   = axi_awburst[1];
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs_c) begin
          w_cnt_d = w_cnt_q + 4'd1;
          if (axi_wlast != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
          if (w_burst_q == BURST_INCR) w_addr_d = w_addr_q + MemAW'(1);
          if (w_cnt_q == w_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Read channel next-state; R_FETCH covers the array read latency
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    r_load_c  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (axi_arvalid && arready_q) begin
          r_id_d    = axi_arid;
          r_addr_d  = axi_araddr[MemAW+2:3];
          r_len_d   = axi_arlen;
          r_burst_d = axi_arburst;
          r_cnt_d   = 4'd0;
          arready_d = 1'b0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        r_load_c  = 1'b1;
        rvalid_d  = 1'b1;
        rid_d     = r_id_q;
        rlast_d   = (r_cnt_q == r_len_q);
        rresp_d   = r_burst_q[1] ? RESP_SLVERR : RESP_OKAY;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (axi_rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (r_cnt_q == r_len_q) begin
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q + 4'd1;
            if (r_burst_q == BURST_INCR) r_addr_d = r_addr_q + MemAW'(1);
            r_state_d = R_FETCH;
          end
        end
      end
      default: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
    end
  end

  // Byte-lane write port; array is deliberately left unreset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < StrbW; b++) begin
        if (axi_wstrb[b]) mem_q[w_addr_q][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  // Read port samples the pre-write word on a same-cycle collision
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (r_load_c) begin
      rdata_q <= r_burst_q[1] ? '0 : mem_q[r_addr_q];
    end
  end

  assign axi_awreadyo = awready_q;
  assign axi_wreadyo  = wready_q;
  assign axi_bvalido  = bvalid_q;
  assign axi_bido     = bid_q;
  assign axi_brespo   = bresp_q;
  assign axi_arreadyo = arready_q;
  assign axi_rvalido  = rvalid_q;
  assign axi_rlasto   = rlast_q;
  assign axi_rido     = rid_q;
  assign axi_rrespo   = rresp_q;
  assign axi_rdatao   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: a word-array model predicts B and R
// responses; a negedge monitor pops and compares every handshake.
module tb_axi_mem_responder;

  localparam int unsigned IdW   = 6;
  localparam int unsigned MemAW = 12;
  localparam int unsigned Depth = 4096;

  logic           clk = 1'b0;
  logic           reset;
  logic [IdW-1:0] axi_awid, axi_arid, axi_bido, axi_rido;
  logic [31:0]    axi_awaddr, axi_araddr;
  logic [3:0]     axi_awlen, axi_arlen;
  logic [1:0]     axi_awburst, axi_arburst, axi_brespo, axi_rrespo;
  logic           axi_awvalid, axi_awreadyo, axi_wlast, axi_wvalid, axi_wreadyo;
  logic [63:0]    axi_wdata, axi_rdatao;
  logic [7:0]     axi_wstrb;
  logic           axi_bvalido, axi_bready, axi_arvalid, axi_arreadyo;
  logic           axi_rlasto, axi_rvalido, axi_rready;

  always #5 clk = ~clk;

  axi_mem_responder #(.AxiIdW(IdW), .MemAW(MemAW)) dut (
    .clk(clk), .reset(reset),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awreadyo(axi_awreadyo),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wreadyo(axi_wreadyo),
    .axi_bido(axi_bido), .axi_brespo(axi_brespo), .axi_bvalido(axi_bvalido),
    .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arreadyo(axi_arreadyo),
    .axi_rido(axi_rido), .axi_rdatao(axi_rdatao), .axi_rrespo(axi_rrespo),
    .axi_rlasto(axi_rlasto), .axi_rvalido(axi_rvalido), .axi_rready(axi_rready)
  );

  typedef struct {logic [IdW-1:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct {logic [IdW-1:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  logic [63:0] ref_mem [Depth];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          r_beats = 0;
  int          r_hold  = 0;
  int          b_hold  = 0;
  bit          rand_bp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // Ready back-pressure on the response channels
  initial begin
    axi_rready = 1'b1;
    axi_bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (r_hold > 0) begin axi_rready = 1'b0; r_hold--; end
      else axi_rready = rand_bp ? 1'($urandom % 2) : 1'b1;
      if (b_hold > 0) begin axi_bready = 1'b0; b_hold--; end
      else axi_bready = rand_bp ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor: compare each handshake against the scoreboard, check held outputs
  initial begin
    logic prev_rv, prev_rh, prev_rlast, prev_bv, prev_bh;
    logic [63:0] prev_rdata;
    logic [IdW-1:0] prev_bid;
    r_exp_t er;
    b_exp_t eb;
    prev_rv = 0; prev_rh = 0; prev_bv = 0; prev_bh = 0;
    prev_rlast = 0; prev_rdata = '0; prev_bid = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_rv = 0;
        prev_bv = 0;
      end else begin
        if (prev_rv && !prev_rh) begin
          check("r_valid_held", 64'(axi_rvalido), 64'd1);
          check("r_data_held", axi_rdatao, prev_rdata);
          check("r_last_held", 64'(axi_rlasto), 64'(prev_rlast));
        end
        if (axi_rvalido && axi_rready) begin
          r_beats++;
          if (exp_r.size() == 0) timeout_fail("r_unexpected_beat");
          else begin
            er = exp_r.pop_front();
            check("r_data", axi_rdatao, er.data);
            check("r_id", 64'(axi_rido), 64'(er.id));
            check("r_resp", 64'(axi_rrespo), 64'(er.resp));
            check("r_last", 64'(axi_rlasto), 64'(er.last));
          end
        end
        prev_rv = axi_rvalido; prev_rh = axi_rvalido && axi_rready;
        prev_rdata = axi_rdatao; prev_rlast = axi_rlasto;

        if (prev_bv && !prev_bh) begin
          check("b_valid_held", 64'(axi_bvalido), 64'd1);
          check("b_id_held", 64'(axi_bido), 64'(prev_bid));
        end
        if (axi_bvalido) check("aw_ready_during_resp", 64'(axi_awreadyo), 64'd0);
        if (axi_bvalido && axi_bready) begin
          if (exp_b.size() == 0) timeout_fail("b_unexpected_resp");
          else begin
            eb = exp_b.pop_front();
            check("b_id", 64'(axi_bido), 64'(eb.id));
            check("b_resp", 64'(axi_brespo), 64'(eb.resp));
          end
        end
        prev_bv = axi_bvalido; prev_bh = axi_bvalido && axi_bready; prev_bid = axi_bido;
      end
    end
  end

  // Wait for a ready (0=aw,1=w,2=ar) seen mid-cycle, then step past the edge
  task automatic wait_ready(input int sel, input string name);
    int  n;
    logic s;
    n = 0;
    forever begin
      @(negedge clk);
      s = (sel == 0) ? axi_awreadyo : (sel == 1) ? axi_wreadyo : axi_arreadyo;
      if (s) break;
      n++;
      if (n > 200) begin timeout_fail(name); break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 500) timeout_fail("drain");
  endtask

  task automatic aw_hs(input logic [IdW-1:0] id, input logic [31:0] addr,
                       input logic [3:0] len, input logic [1:0] burst);
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst;
    axi_awvalid = 1'b1;
    wait_ready(0, "aw_handshake");
    axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    axi_wdata = d; axi_wstrb = s; axi_wlast = l; axi_wvalid = 1'b1;
    wait_ready(1, "w_handshake");
  endtask

  // Write burst from wd/ws; bad >= 0 flips wlast on that beat
  task automatic wr(input logic [IdW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, input int bad);
    int  a;
    bit  err, lst, wl;
    a   = int'(addr >> 3) % Depth;
    err = (burst > 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      lst = (i == int'(len));
      wl  = (i == bad) ? !lst : lst;
      if (wl != lst) err = 1'b1;
      if (burst <= 2'b01)
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) ref_mem[a][8*b +: 8] = wd[i][8*b +: 8];
      if (burst == 2'b01) a = (a + 1) % Depth;
    end
    exp_b.push_back('{id, err ? 2'b10 : 2'b00});
    aw_hs(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++)
      w_beat(wd[i], ws[i], (i == bad) ? (i != int'(len)) : (i == int'(len)));
    axi_wvalid = 1'b0;
    drain();
  endtask

  task automatic rd(input logic [IdW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, input bit wait_done);
    int a;
    a = int'(addr >> 3) % Depth;
    for (int i = 0; i <= int'(len); i++) begin
      exp_r.push_back('{id, (burst > 2'b01) ? 64'd0 : ref_mem[a],
                        (burst > 2'b01) ? 2'b10 : 2'b00, i == int'(len)});
      if (burst == 2'b01) a = (a + 1) % Depth;
    end
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst;
    axi_arvalid = 1'b1;
    wait_ready(2, "ar_handshake");
    axi_arvalid = 1'b0;
    if (wait_done) drain();
  endtask

  task automatic fill(input bit rand_strb);
    for (int i = 0; i < 16; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = rand_strb ? 8'($urandom) : 8'hFF;
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    int          base, bad, sel, start, n;
    logic [31:0] bases [5];

    reset = 1'b0;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awburst = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arburst = '0; axi_arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(axi_awreadyo), 64'd0);
    check("rst_wready", 64'(axi_wreadyo), 64'd0);
    check("rst_bvalid", 64'(axi_bvalido), 64'd0);
    check("rst_arready", 64'(axi_arreadyo), 64'd0);
    check("rst_rvalid", 64'(axi_rvalido), 64'd0);
    check("rst_rlast", 64'(axi_rlasto), 64'd0);
    check("rst_bid", 64'(axi_bido), 64'd0);
    check("rst_rid", 64'(axi_rido), 64'd0);
    check("rst_rdata", axi_rdatao, 64'd0);
    check("rst_bresp", 64'(axi_brespo), 64'd0);
    check("rst_rresp", 64'(axi_rrespo), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("awready_after_rst", 64'(axi_awreadyo), 64'd1);
    check("arready_after_rst", 64'(axi_arreadyo), 64'd1);

    // Prefill words 0..79 and 4080..4095 so every later read is defined
    bases[0] = 32'h0; bases[1] = 32'h80; bases[2] = 32'h100;
    bases[3] = 32'h180; bases[4] = 32'h7F80;
    for (int k = 0; k < 5; k++) begin
      fill(1'b0);
      wr(6'h01, bases[k], 4'd15, 2'b01, -1);
    end
    fill(1'b0);
    wr(6'h01, 32'h200, 4'd15, 2'b01, -1);

    // Four-beat INCR write and read-back at 0x100
    wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
    wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    wr(6'h05, 32'h100, 4'd3, 2'b01, -1);
    rd(6'h09, 32'h100, 4'd3, 2'b01, 1'b1);

    // Partial strobe merge
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    wr(6'h02, 32'h200, 4'd0, 2'b01, -1);
    wd[0] = 64'hAAAA_AAAA_BBBB_BBBB; ws[0] = 8'h0F;
    wr(6'h03, 32'h200, 4'd0, 2'b01, -1);
    rd(6'h04, 32'h200, 4'd0, 2'b01, 1'b1);
    check("strobe_merge_model", ref_mem[64], 64'hFFFF_FFFF_BBBB_BBBB);

    // FIXED burst overwrites one word only
    wd[0] = 64'd1; wd[1] = 64'd2; wd[2] = 64'd3;
    for (int i = 0; i < 3; i++) ws[i] = 8'hFF;
    wr(6'h06, 32'h40, 4'd2, 2'b00, -1);
    rd(6'h07, 32'h40, 4'd2, 2'b01, 1'b1);

    // Error cases: unsupported write, early wlast, unsupported read
    fill(1'b0);
    wr(6'h0A, 32'h80, 4'd1, 2'b10, -1);
    rd(6'h0B, 32'h80, 4'd1, 2'b01, 1'b1);
    fill(1'b0);
    wr(6'h0C, 32'hC0, 4'd1, 2'b01, 0);
    rd(6'h0D, 32'h80, 4'd2, 2'b10, 1'b1);

    // rready held low mid-burst, then bready held low
    start = r_beats;
    rd(6'h0E, 32'h100, 4'd3, 2'b01, 1'b0);
    n = 0;
    while (r_beats < start + 2 && n < 200) begin @(posedge clk); n++; end
    #1;
    if (n >= 200) timeout_fail("r_mid_burst");
    r_hold = 5;
    drain();
    b_hold = 10;
    fill(1'b0);
    wr(6'h0F, 32'h180, 4'd0, 2'b01, -1);

    // Randomized traffic with aliasing, wrap, random strobes and back-pressure
    rand_bp = 1'b1;
    for (int it = 0; it < 60; it++) begin
      base  = ($urandom % 2) ? int'($urandom % 40) : 4085 + int'($urandom % 11);
      addr  = ($urandom & 32'hFFFF_8000) | (32'(base) << 3) | ($urandom & 32'h7);
      len   = 4'($urandom);
      sel   = int'($urandom % 8);
      burst = (sel == 0) ? 2'b00 : (sel < 6) ? 2'b01 : (sel == 6) ? 2'b10 : 2'b11;
      if ($urandom % 2) begin
        bad = ($urandom % 6 == 0) ? int'($urandom % (32'(len) + 1)) : -1;
        fill(1'b1);
        wr(6'($urandom), addr, len, burst, bad);
      end else begin
        rd(6'($urandom), addr, len, burst, 1'b1);
      end
    end
    rand_bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during beat 2 of a 4-beat write abandons it without a response
    fill(1'b0);
    aw_hs(6'h11, 32'h300, 4'd3, 2'b01);
    w_beat(wd[0], ws[0], 1'b0);
    w_beat(wd[1], ws[1], 1'b0);
    axi_wdata = wd[2];
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_awready", 64'(axi_awreadyo), 64'd0);
    check("mid_rst_wready", 64'(axi_wreadyo), 64'd0);
    check("mid_rst_bvalid", 64'(axi_bvalido), 64'd0);
    check("mid_rst_arready", 64'(axi_arreadyo), 64'd0);
    check("mid_rst_rvalid", 64'(axi_rvalido), 64'd0);
    check("mid_rst_rlast", 64'(axi_rlasto), 64'd0);
    reset = 1'b1;
    axi_wvalid = 1'b0;
    @(posedge clk);
    #1;
    check("awready_after_mid_rst", 64'(axi_awreadyo), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_bvalid_after_rst", 64'(axi_bvalido), 64'd0);
    end
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);
    check("r_queue_empty", 64'(exp_r.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
